uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

Parametrised UART receiver that replaces the fixed toggled-clock UART path with a single-clock-domain engine. It derives a 16x oversampling tick from `clk`, synchronises and majority-samples `rx`, and checks configurable parity and stop bits. Each received frame, with its error flags, is pushed into a small FIFO drained by a valid/ready handshake. It sits between the board UART_RX pin and any consumer logic (LED/PMOD debug, command parsers).

## Interface
- `CLK_HZ`, 100_000_000: `clk` frequency in Hz.
- `BAUD`, 115200: line rate.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, sent LSB first.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial line, idles high.
- `rx_data` out DATA_BITS: FIFO head data.
- `rx_parity_err` out 1: parity error flag of the head entry.
- `rx_frame_err` out 1: stop-bit error flag of the head entry.
- `rx_break` out 1: break flag of the head entry.
- `rx_valid` out 1: FIFO is non-empty.
- `rx_ready` in 1: consumer accepts the head entry.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Divider:** DIV = round(CLK_HZ/(BAUD*16)), which is 54 at the defaults. The counter runs 0..DIV-1 and emits a one-cycle `tick` on wrap. The counter is cleared in IDLE so the start-bit phase aligns to the line.
- **Synchroniser:** two flops on `rx`, reset to 1. Every later reference to `rx` means the synchronised value.
- **Sampling:** each bit spans 16 ticks. Its value is the majority of the samples taken at ticks 7, 8 and 9.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE:** a low `rx` moves the FSM to START.
- **START:** a voted 1 is a false start, and the FSM returns to IDLE with no entry written. A voted 0 moves to DATA.
- **DATA:** DATA_BITS bits are shifted in, LSB first. Next state is PARITY if PARITY≠0, otherwise STOP.
- **PARITY:** `parity_err` is set if the data bits plus the parity bit have the wrong number of ones for the selected even/odd mode.
- **STOP:** STOP_BITS stop bits are sampled. Any stop bit that votes 0 sets `frame_err`.
- **Break:** `break` is set when `frame_err` is set, all data bits are 0 and any parity bit is 0. After a break the FSM goes to WAIT_IDLE and stays there until `rx` = 1, then returns to IDLE.
- **Frame end:** on the final stop-bit vote, {data, parity_err, frame_err, break} is pushed. The FSM then moves to IDLE (or WAIT_IDLE after a break).
- **FIFO pop:** occurs when `rx_valid && rx_ready`. A pop while empty is ignored.
- **Push when full:**
  - With a simultaneous pop, the push succeeds and the level is unchanged.
  - Without a pop, the frame is dropped and `overrun` pulses for one cycle. Existing entries are untouched.
- **Pointers:** wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:** all outputs 0, `fifo_level` 0, FSM in IDLE, divider 0, shift register 0.
- **Reset mid-frame:** aborts the frame and discards the FIFO contents.
- **Start detection:** 2 cycles of synchroniser latency from the `rx` falling edge to leaving IDLE.
- **Push timing:** the push happens on the clk edge that samples the final stop-bit tick 9.
  - `rx_valid`, `fifo_level` and the head outputs update in the following cycle.
- **Head outputs:**
  - Come from registered FIFO read data.
  - Stable while `rx_valid && !rx_ready`.
  - Update in the cycle after a pop.
- **Busy:** `busy` deasserts in the same cycle the FSM enters IDLE.
- **Back-to-back frames:** a next start bit arriving right after a stop bit is accepted. IDLE is re-entered before the second half of the stop bit.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum.
  - Parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - Function `uart_div(clk_hz, baud)` returning the rounded DIV.
  - FIFO entry struct {data, parity_err, frame_err, break}.
- **Sub-module:** `uart_rx_fifo`, a parametrised synchronous FIFO with width and depth parameters, push/pop/full/empty/level ports. The FSM, divider and voter stay in `uart_rx_engine`.

## Test plan
- **Clean 8N1 frame:** defaults, send 0xA5 at 115200 → `rx_data`=0xA5, all error flags 0, `fifo_level`=1; pop → `rx_valid`=0.
- **Parity error:** PARITY=1, send 0x03 with parity bit 1 → `rx_data`=0x03, `rx_parity_err`=1, `rx_frame_err`=0.
- **Glitch rejection:** `rx` low for 162 clk (3 ticks) then high → no entry, `busy` returns to 0, `fifo_level`=0.
- **Overrun:** `rx_ready`=0, send 0x01..0x05 → `fifo_level`=4, `overrun` pulses once, after the fifth frame; drain yields 0x01, 0x02, 0x03, 0x04.
- **Break:** `rx` low for 20 bit times, then high → exactly one entry: data 0x00, `rx_frame_err`=1, `rx_break`=1; no further entries while low.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x77 → `fifo_level`=0, `busy`=0; next frame 0x5A → `rx_data`=0x5A with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_e;

    localparam int PAR_NONE      = 0;
    localparam int PAR_EVEN      = 1;
    localparam int PAR_ODD       = 2;
    localparam int MAX_DATA_BITS = 9;

    // Sized for the widest legal frame; narrower frames leave the upper data bits zero.
    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     parity_err;
        logic                     frame_err;
        logic                     brk;
    } rx_entry_t;

    function automatic int uart_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud * 8) / (baud * 16));
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head; the head updates the cycle after a push into empty or a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + (AW+1)'(1);
        else if (!do_push && do_pop)
            count_d = count_q - (AW+1)'(1);
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            // The incoming word becomes the head when nothing older survives this cycle.
            if (do_push && (empty_o || (count_q == (AW+1)'(1) && do_pop)))
                head_q <= wdata_i;
            else if (do_pop)
                head_q <= mem_q[rd_ptr_q + AW'(1)];
        end
    end

    assign rdata_o = head_q;
    assign level_o = count_q;

endmodule

// File: rtl/uart_rx_engine.sv
// Single-clock UART receiver: 16x tick divider, rx synchroniser, 3-sample majority voter, frame FSM and FIFO.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_break,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int DIV_W = $clog2(DIV);

    rx_state_e            state_q;
    logic [DIV_W-1:0]     div_q;
    logic [3:0]           tick_cnt_q, bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 rx_meta_q, rx_sync_q, s7_q, s8_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q, par_bit_q, frame_err_q, overrun_q;
    logic                 tick, vote, vote_stb, bit_end, last_stop, push, pop;
    logic                 fifo_full, fifo_empty;
    rx_entry_t            push_entry, head;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Held at zero in IDLE so the first tick lands a fixed distance after the start edge.
    always_ff @(posedge clk) begin
        if (reset || state_q == S_IDLE || tick) div_q <= '0;
        else                                     div_q <= div_q + DIV_W'(1);
    end

    assign tick      = (div_q == DIV_W'(DIV - 1));
    assign vote_stb  = tick && (tick_cnt_q == 4'd8);
    assign bit_end   = tick && (tick_cnt_q == 4'd15);
    assign vote      = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);
    assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

    always_comb begin
        push_entry                      = '0;
        push_entry.data[DATA_BITS-1:0]  = shift_q;
        push_entry.parity_err           = par_err_q;
        push_entry.frame_err            = frame_err_q | ~vote;
        push_entry.brk                  = push_entry.frame_err && (shift_q == '0) &&
                                          (PARITY == PAR_NONE || !par_bit_q);
        push                            = (state_q == S_STOP) && vote_stb && last_stop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd6) s7_q <= rx_sync_q;
                if (tick_cnt_q == 4'd7) s8_q <= rx_sync_q;
            end
            case (state_q)
                S_IDLE: begin
                    tick_cnt_q  <= '0;
                    bit_cnt_q   <= '0;
                    stop_cnt_q  <= 1'b0;
                    par_err_q   <= 1'b0;
                    par_bit_q   <= 1'b0;
                    frame_err_q <= 1'b0;
                    if (!rx_sync_q) state_q <= S_START;
                end
                S_START: begin
                    if (vote_stb && vote) state_q <= S_IDLE;
                    else if (bit_end)     state_q <= S_DATA;
                end
                S_DATA: begin
                    if (vote_stb) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(DATA_BITS - 1))
                            state_q <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (vote_stb) begin
                        par_bit_q <= vote;
                        par_err_q <= (^shift_q) ^ vote ^ (PARITY == PAR_ODD);
                    end
                    if (bit_end) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (push)          state_q <= push_entry.brk ? S_WAIT_IDLE : S_IDLE;
                    else if (vote_stb) frame_err_q <= frame_err_q | ~vote;
                    if (bit_end) stop_cnt_q <= 1'b1;
                end
                S_WAIT_IDLE: begin
                    if (rx_sync_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pop = rx_ready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= push && fifo_full && !pop;
    end

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign rx_data       = head.data[DATA_BITS-1:0];
    assign rx_parity_err = head.parity_err;
    assign rx_frame_err  = head.frame_err;
    assign rx_break      = head.brk;
    assign rx_valid      = !fifo_empty;
    assign overrun       = overrun_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: 8N1 instance plus an even-parity instance, run at a fast baud.
module tb_uart_rx_engine;

    // 100 MHz / (460800*16) = 13.56 -> DIV 14, so one bit is 224 clk and one tick 14 clk.
    localparam int BAUD_TB  = 460800;
    localparam int BIT_CLKS = 16 * 14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1, rx_ready = 1'b0;
    logic       rx_p = 1'b1, rx_ready_p = 1'b0;
    logic [7:0] rx_data, rx_data_p;
    logic       pe, fe, brk, valid, ovr, busy;
    logic       pe_p, fe_p, brk_p, valid_p, ovr_p, busy_p;
    logic [2:0] level, level_p;

    int n_cmp = 0;
    int n_mis = 0;
    int ovr_cnt = 0;
    int ovr_base;

    always #5 clk = ~clk;

    uart_rx_engine #(.BAUD(BAUD_TB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_parity_err(pe),
        .rx_frame_err(fe), .rx_break(brk), .rx_valid(valid), .rx_ready(rx_ready),
        .overrun(ovr), .fifo_level(level), .busy(busy)
    );

    uart_rx_engine #(.BAUD(BAUD_TB), .PARITY(1)) dut_par (
        .clk(clk), .reset(reset), .rx(rx_p), .rx_data(rx_data_p), .rx_parity_err(pe_p),
        .rx_frame_err(fe_p), .rx_break(brk_p), .rx_valid(valid_p), .rx_ready(rx_ready_p),
        .overrun(ovr_p), .fifo_level(level_p), .busy(busy_p)
    );

    always @(negedge clk) if (ovr) ovr_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = 1'b1;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame_p(input logic [7:0] d, input logic pbit);
        rx_p = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_p = d[i];
            wait_clks(BIT_CLKS);
        end
        rx_p = pbit;
        wait_clks(BIT_CLKS);
        rx_p = 1'b1;
        wait_clks(BIT_CLKS);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
    endtask

    task automatic pop_one_p();
        rx_ready_p = 1'b1;
        wait_clks(1);
        rx_ready_p = 1'b0;
    endtask

    initial begin
        wait_clks(4);
        reset = 1'b0;
        wait_clks(1);
        check("reset_valid", valid, 0);
        check("reset_level", level, 0);
        check("reset_busy", busy, 0);
        check("reset_data", rx_data, 0);
        check("reset_flags", {pe, fe, brk, ovr}, 0);

        // Clean 8N1 frame
        send_frame(8'hA5);
        check("a5_data", rx_data, 8'hA5);
        check("a5_flags", {pe, fe, brk}, 0);
        check("a5_level", level, 1);
        check("a5_valid", valid, 1);
        pop_one();
        check("a5_pop_valid", valid, 0);
        check("a5_pop_level", level, 0);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong and parity bit 0 is right
        send_frame_p(8'h03, 1'b1);
        check("par_bad_data", rx_data_p, 8'h03);
        check("par_bad_pe", pe_p, 1);
        check("par_bad_fe", fe_p, 0);
        pop_one_p();
        send_frame_p(8'h07, 1'b1);
        check("par_good_data", rx_data_p, 8'h07);
        check("par_good_pe", pe_p, 0);
        pop_one_p();

        // Glitch: low for 3 ticks only
        rx = 1'b0;
        wait_clks(20);
        check("glitch_busy_hi", busy, 1);
        wait_clks(3 * 14 - 20);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_busy_lo", busy, 0);
        check("glitch_level", level, 0);

        // Overrun: five back-to-back frames with no consumer
        ovr_base = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i));
        check("ovr_level4", level, 4);
        check("ovr_none_yet", ovr_cnt - ovr_base, 0);
        send_frame(8'h05);
        check("ovr_pulse_once", ovr_cnt - ovr_base, 1);
        check("ovr_level_full", level, 4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_drain%0d", i), rx_data, i);
            pop_one();
        end
        check("ovr_drained", valid, 0);

        // Break: line low for 20 bit times
        rx = 1'b0;
        wait_clks(19 * BIT_CLKS);
        check("brk_level_low", level, 1);
        check("brk_wait_busy", busy, 1);
        check("brk_entry", {rx_data, pe, fe, brk}, {8'h00, 1'b0, 1'b1, 1'b1});
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check("brk_level_end", level, 1);
        check("brk_idle", busy, 0);
        pop_one();

        // Reset mid-frame with an entry already queued
        send_frame(8'h11);
        check("rst_pre_level", level, 1);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end
        rx = 1'b0;
        wait_clks(BIT_CLKS / 2);
        check("rst_pre_busy", busy, 1);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        rx = 1'b1;
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        wait_clks(2 * BIT_CLKS);
        check("rst_quiet_busy", busy, 0);
        send_frame(8'h5A);
        check("rst_next_entry", {rx_data, pe, fe, brk}, {8'h5A, 3'b000});
        check("rst_next_level", level, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
